pad_release_seq: RTL and testbench
==================================

PAD_RELEASE_SEQ -- requirements
Module: pad_release_seq

Interface
REQ-001 SHALL have parameter NUM_PADS, default 40: number of bidir pads controlled.
REQ-002 SHALL have parameter NUM_GROUPS, default 4: release groups; pad i belongs to group (i mod NUM_GROUPS); legal range 1..NUM_PADS.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: reset synchronizer depth; legal value >=2.
REQ-004 SHALL have parameter GROUP_DELAY, default 16: clocks between group releases; legal value >=1.
REQ-005 SHALL have parameters SAFE_PU and SAFE_PD, each NUM_PADS bits, default all 0: pull state driven while a pad is gated.
REQ-006 SHALL have port clk, input, 1 bit: the block's one clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports core_oe, core_pu, core_pd, each input, NUM_PADS bits: raw pad controls from the core.
REQ-009 SHALL have port force_safe, input, 1 bit: synchronous request to return all pads to the safe state.
REQ-010 SHALL have ports pad_oe, pad_pu, pad_pd, each output, NUM_PADS bits: gated controls to the pads.
REQ-011 SHALL have port core_rst_n, output, 1 bit: synchronized, active-low core reset.
REQ-012 SHALL have port released, output, 1 bit: high when all groups are enabled.
REQ-013 SHALL have port grp_en, output, NUM_GROUPS bits: registered per-group enable mask.

Function
REQ-014 SHALL build the synchronizer as a SYNC_STAGES-flop chain, set to 1 asynchronously by rst and shifting in 0; internal rst_sync is the last stage, so rst_sync falls on the SYNC_STAGES-th rising edge after rst falls.
REQ-015 SHALL implement the FSM states SYNC, WAIT, RELEASE, RUN and SAFE, all registered.
REQ-016 SHALL remain in SYNC while rst_sync=1; on the first edge with rst_sync=0 it SHALL enter WAIT, set core_rst_n=1 and load the delay counter with GROUP_DELAY-1.
REQ-017 In WAIT/RELEASE the counter SHALL decrement each clock; at counter==0 the next edge SHALL set the next grp_en bit (ascending from 0) and reload GROUP_DELAY-1; WAIT->RELEASE on the first set.
REQ-018 On the edge that sets grp_en[NUM_GROUPS-1], the FSM SHALL enter RUN and set released=1.
REQ-019 Group g SHALL be enabled on rising edge SYNC_STAGES+1+(g+1)*GROUP_DELAY, counting from rst deassertion.
REQ-020 With enabled = grp_en[i mod NUM_GROUPS], pad_oe[i] SHALL be core_oe[i]&enabled, pad_pu[i] SHALL be enabled?core_pu[i]:SAFE_PU[i] and pad_pd[i] SHALL be enabled?core_pd[i]:SAFE_PD[i]; this path is combinational from registered enables only.
REQ-021 A gated pad SHALL never have pad_pu[i] and pad_pd[i] high together; if SAFE_PU[i]&SAFE_PD[i], SAFE_PD[i] SHALL be forced to 0.
REQ-022 force_safe=1 sampled in WAIT, RELEASE or RUN SHALL, at the next edge, select SAFE, clear grp_en and released, and leave core_rst_n=1.
REQ-023 The FSM SHALL stay in SAFE while force_safe=1; force_safe=0 sampled in SAFE SHALL enter WAIT with the counter loaded, restarting the REQ-017 sequence.
REQ-024 force_safe SHALL be ignored in SYNC.
REQ-025 The counter width SHALL be $clog2(GROUP_DELAY+1), with no wrap beyond the reload value.

Reset
REQ-026 rst assertion SHALL, without a clock and regardless of state (including mid-release), set state=SYNC, all sync flops=1, core_rst_n=0, grp_en=0, released=0 and counter=0, so all pads SHALL immediately show oe=0 and the safe pulls.
REQ-027 Deassertion SHALL be honoured only via the synchronizer (REQ-014); no output SHALL change combinationally on rst falling.

Verification (NUM_PADS=8, NUM_GROUPS=4, SYNC_STAGES=2, GROUP_DELAY=3, SAFE_PU=8'h0F, SAFE_PD=8'hF0)
REQ-028 Release sequence: core_oe=8'hFF, rst falls -> core_rst_n=1 at edge 3; grp_en=0001 at edge 6, 0011 at 9, 0111 at 12, 1111 at 15 with released=1; pad_oe=8'h11,33,77,FF respectively.
REQ-029 Safe pulls: during reset with core_pu=8'hFF and core_pd=0 -> pad_pu=8'h0F, pad_pd=8'hF0; after edge 15 -> pad_pu=8'hFF, pad_pd=8'h00.
REQ-030 Mid-release reset: assert rst between edges 10 and 11 -> pad_oe=0 and grp_en=0 at once, without a clock; after deassertion the sequence repeats exactly per REQ-028.
REQ-031 force_safe pulse of 2 cycles in RUN -> next edge grp_en=0, pad_oe=0, core_rst_n stays 1; after release, group 0 re-enables 3 edges after WAIT is entered, and all groups after 12.
REQ-032 Short reset glitch: rst high for less than 1 clk period -> core_rst_n low for at least SYNC_STAGES+1 edges, with no X on any output.
REQ-033 Boundary parameters: NUM_GROUPS=1, GROUP_DELAY=1 -> all pads enabled on edge SYNC_STAGES+2; force_safe held through reset release -> FSM holds in SAFE immediately after WAIT.

Source files
------------

// File: rtl/pad_release_seq.sv
// pad_release_seq: holds bidir pads in a safe state until reset is synchronized, then releases them group by group.
module pad_release_seq #(
  parameter int NUM_PADS = 40,
  parameter int NUM_GROUPS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int GROUP_DELAY = 16,
  parameter logic [NUM_PADS-1:0] SAFE_PU = '0,
  parameter logic [NUM_PADS-1:0] SAFE_PD = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PADS-1:0]   core_oe,
  input  logic [NUM_PADS-1:0]   core_pu,
  input  logic [NUM_PADS-1:0]   core_pd,
  input  logic                  force_safe,
  output logic [NUM_PADS-1:0]   pad_oe,
  output logic [NUM_PADS-1:0]   pad_pu,
  output logic [NUM_PADS-1:0]   pad_pd,
  output logic                  core_rst_n,
  output logic                  released,
  output logic [NUM_GROUPS-1:0] grp_en
);
  localparam int CW = $clog2(GROUP_DELAY + 1);
  localparam logic [CW-1:0] RELOAD = CW'(GROUP_DELAY - 1);
  // pull-down yields to pull-up so a gated pad never fights itself
  localparam logic [NUM_PADS-1:0] SAFE_PD_EFF = SAFE_PD & ~SAFE_PU;
  typedef enum logic [2:0] {SYNC, WAIT, RELEASE, RUN, SAFE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic rst_sync;
  logic [CW-1:0] cnt, cnt_nx;
  logic [NUM_GROUPS-1:0] grp_nx, grp_step;
  logic released_nx, core_rst_n_nx;
  logic [NUM_PADS-1:0] en;
  assign rst_sync = sync[SYNC_STAGES-1];
  assign grp_step = (grp_en << 1) | NUM_GROUPS'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '1;
      state <= SYNC;
      cnt <= '0;
      grp_en <= '0;
      released <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b0};
      state <= state_nx;
      cnt <= cnt_nx;
      grp_en <= grp_nx;
      released <= released_nx;
      core_rst_n <= core_rst_n_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    grp_nx = grp_en;
    released_nx = released;
    core_rst_n_nx = core_rst_n;
    case (state)
      SYNC: if (!rst_sync) begin
        state_nx = WAIT;
        core_rst_n_nx = 1'b1;
        cnt_nx = RELOAD;
      end
      WAIT, RELEASE: if (force_safe) begin
        state_nx = SAFE;
        grp_nx = '0;
        released_nx = 1'b0;
      end else if (cnt == '0) begin
        grp_nx = grp_step;
        cnt_nx = RELOAD;
        state_nx = grp_step[NUM_GROUPS-1] ? RUN : RELEASE;
        released_nx = grp_step[NUM_GROUPS-1];
      end else begin
        cnt_nx = cnt - CW'(1);
      end
      RUN: if (force_safe) begin
        state_nx = SAFE;
        grp_nx = '0;
        released_nx = 1'b0;
      end
      SAFE: if (!force_safe) begin
        state_nx = WAIT;
        cnt_nx = RELOAD;
      end
      default: state_nx = SYNC;
    endcase
  end
  for (genvar g = 0; g < NUM_PADS; g++) begin : g_en
    assign en[g] = grp_en[g % NUM_GROUPS];
  end
  assign pad_oe = core_oe & en;
  assign pad_pu = (core_pu & en) | (SAFE_PU & ~en);
  assign pad_pd = (core_pd & en) | (SAFE_PD_EFF & ~en);
endmodule

// File: tb/tb_pad_release_seq.sv
// tb_pad_release_seq: random stimulus against an edge-counting model of the release sequence, two parameter sets.
module tb_pad_release_seq;
  localparam int SS = 2;
  localparam int NG0 = 4, GD0 = 3, NG1 = 1, GD1 = 1;
  localparam logic [7:0] PU0 = 8'h0F, PD0 = 8'hF0, PU1 = 8'h3C, PD1 = 8'h0F;
  logic clk = 0, rst = 1, force_safe = 0;
  logic [7:0] core_oe = 0, core_pu = 0, core_pd = 0;
  logic [7:0] oe_a, pu_a, pd_a, oe_b, pu_b, pd_b;
  logic crn_a, rel_a, crn_b, rel_b;
  logic [3:0] ge_a;
  logic [0:0] ge_b;
  int n_chk = 0, n_err = 0;
  int since[2], w[2];
  bit act[2], saf[2];

  pad_release_seq #(.NUM_PADS(8), .NUM_GROUPS(NG0), .SYNC_STAGES(SS), .GROUP_DELAY(GD0),
    .SAFE_PU(PU0), .SAFE_PD(PD0)) dut_a (
    .clk(clk), .rst(rst), .core_oe(core_oe), .core_pu(core_pu), .core_pd(core_pd),
    .force_safe(force_safe), .pad_oe(oe_a), .pad_pu(pu_a), .pad_pd(pd_a),
    .core_rst_n(crn_a), .released(rel_a), .grp_en(ge_a));

  pad_release_seq #(.NUM_PADS(8), .NUM_GROUPS(NG1), .SYNC_STAGES(SS), .GROUP_DELAY(GD1),
    .SAFE_PU(PU1), .SAFE_PD(PD1)) dut_b (
    .clk(clk), .rst(rst), .core_oe(core_oe), .core_pu(core_pu), .core_pd(core_pd),
    .force_safe(force_safe), .pad_oe(oe_b), .pad_pu(pu_b), .pad_pd(pd_b),
    .core_rst_n(crn_b), .released(rel_b), .grp_en(ge_b));

  always #5 clk = ~clk;

  // model: edges since reset release, then edges since the last entry into the waiting phase
  always @(posedge clk or posedge rst)
    for (int d = 0; d < 2; d++)
      if (rst) begin
        since[d] <= 0;
        w[d] <= 0;
        act[d] <= 0;
        saf[d] <= 0;
      end else if (act[d]) begin
        if (force_safe) begin
          act[d] <= 0;
          saf[d] <= 1;
        end else w[d] <= w[d] + 1;
      end else if (saf[d]) begin
        if (!force_safe) begin
          saf[d] <= 0;
          act[d] <= 1;
          w[d] <= 0;
        end
      end else if (since[d] == SS) begin
        act[d] <= 1;
        w[d] <= 0;
      end else since[d] <= since[d] + 1;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int ng, gd, k;
      logic [7:0] pu_s, pd_s, eoe, epu, epd;
      logic [3:0] eg;
      logic en;
      ng = d ? NG1 : NG0;
      gd = d ? GD1 : GD0;
      k = act[d] ? w[d] / gd : 0;
      if (k > ng) k = ng;
      eg = 4'((1 << k) - 1);
      pu_s = d ? PU1 : PU0;
      pd_s = (d ? PD1 : PD0) & ~pu_s;
      for (int i = 0; i < 8; i++) begin
        en = eg[i % ng];
        eoe[i] = core_oe[i] & en;
        epu[i] = en ? core_pu[i] : pu_s[i];
        epd[i] = en ? core_pd[i] : pd_s[i];
      end
      chk(d ? "b_grp_en" : "a_grp_en", d ? 8'(ge_b) : 8'(ge_a), 8'(eg));
      chk(d ? "b_released" : "a_released", d ? 8'(rel_b) : 8'(rel_a), 8'(act[d] && k == ng));
      chk(d ? "b_core_rst_n" : "a_core_rst_n", d ? 8'(crn_b) : 8'(crn_a), 8'(act[d] || saf[d]));
      chk(d ? "b_pad_oe" : "a_pad_oe", d ? oe_b : oe_a, eoe);
      chk(d ? "b_pad_pu" : "a_pad_pu", d ? pu_b : pu_a, epu);
      chk(d ? "b_pad_pd" : "a_pad_pd", d ? pd_b : pd_a, epd);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    core_oe = 8'($urandom);
    core_pu = 8'($urandom);
    core_pd = 8'($urandom);
  endtask

  task automatic glitch();
    @(posedge clk);
    #2 rst = 1;
    #1 check_all();
    #1 rst = 0;
  endtask

  initial begin
    core_oe = 8'hFF;
    core_pu = 8'hFF;
    core_pd = 8'h00;
    #1 check_all();
    repeat (3) cyc();
    rst = 0;
    repeat (20) cyc();
    rst = 1;
    repeat (2) cyc();
    rst = 0;
    repeat (8) cyc();
    glitch();
    repeat (3) cyc();
    rst = 1;
    #1 check_all();
    repeat (2) cyc();
    rst = 0;
    repeat (20) cyc();
    force_safe = 1;
    repeat (2) cyc();
    force_safe = 0;
    repeat (20) cyc();
    rst = 1;
    force_safe = 1;
    repeat (2) cyc();
    rst = 0;
    repeat (10) cyc();
    force_safe = 0;
    repeat (20) cyc();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) force_safe = ~force_safe;
      if ($urandom_range(0, 59) == 0) glitch();
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
